// File: rtl/vend_pkg.sv
// Shared types and constants for the coin scheduler and the vending core.
package vend_pkg;

    localparam int NUM_COINS = 3;

    typedef enum logic [1:0] {
        COIN_N = 2'd0,
        COIN_D = 2'd1,
        COIN_Q = 2'd2
    } coin_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } sched_state_e;

    // Change codes reported by design_1 alongside a vend.
    localparam logic [2:0] CHG_NONE = 3'b000;
    localparam logic [2:0] CHG_5    = 3'b001;
    localparam logic [2:0] CHG_10   = 3'b010;
    localparam logic [2:0] CHG_15   = 3'b011;
    localparam logic [2:0] CHG_20   = 3'b100;

    function automatic coin_e next_coin(input coin_e c);
        case (c)
            COIN_N:  next_coin = COIN_D;
            COIN_D:  next_coin = COIN_Q;
            default: next_coin = COIN_N;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way combinational round-robin picker: first requester after 'last'.
module rr_arb3 import vend_pkg::*; (
    input  logic [2:0] req,
    input  coin_e      last,
    output logic [2:0] gnt,
    output coin_e      gnt_idx
);

    always_comb begin
        coin_e cand;
        gnt     = 3'b000;
        gnt_idx = last;
        cand    = last;
        for (int k = 0; k < NUM_COINS; k++) begin
            cand = next_coin(cand);
            if (gnt == 3'b000 && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vend_coin_sched.sv
// Coin scheduler: buffers sensor pulses, forwards one coin per cycle round-robin,
// and freezes coin delivery for a fixed window after each vend.
module vend_coin_sched import vend_pkg::*; #(
    parameter int MAX_PEND    = 3,
    parameter int HOLD_CYCLES = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         nickle_i,
    input  logic         dime_i,
    input  logic         quarter_i,
    input  logic         soda_i,
    input  logic [2:0]   change_i,
    output logic         nickle_o,
    output logic         dime_o,
    output logic         quarter_o,
    output logic         soda_o,
    output logic [2:0]   change_o,
    output logic         reject_o,
    output logic         busy_o,
    output sched_state_e dbg_state_o
);

    localparam int CNT_W  = $clog2(MAX_PEND + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_PEND);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    sched_state_e           state_q, state_d;
    logic [2:0][CNT_W-1:0]  cnt_q, cnt_d;
    coin_e                  last_q, last_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [2:0]             strobe_q, strobe_d;
    logic                   soda_q, soda_d;
    logic [2:0]             change_q, change_d;
    logic                   reject_q, reject_d;
    logic                   busy_q, busy_d;

    logic [2:0] pulse;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] gnt_eff;
    coin_e      gnt_idx;
    logic       gnt_en;
    logic       any_pend;

    assign pulse = {quarter_i, dime_i, nickle_i};

    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    rr_arb3 u_arb (
        .req     (req),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The last hold cycle already decides a grant so the first strobe lands
    // exactly HOLD_CYCLES edges after the vend; a vend in the deciding cycle wins.
    assign gnt_en  = !soda_i &&
                     ((state_q == S_ISSUE) || (state_q == S_HOLD && hold_q == '0));
    assign gnt_eff = gnt_en ? gnt : 3'b000;

    always_comb begin
        cnt_d    = cnt_q;
        reject_d = 1'b0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (pulse[i] && !gnt_eff[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    reject_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!pulse[i] && gnt_eff[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        any_pend = (cnt_d != '0);
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        soda_d   = 1'b0;
        change_d = change_q;
        last_d   = (gnt_eff != 3'b000) ? gnt_idx : last_q;
        if (soda_i) begin
            state_d  = S_HOLD;
            hold_d   = HOLD_INIT;
            soda_d   = 1'b1;
            change_d = change_i;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_pend) state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (!any_pend) state_d = S_IDLE;
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        state_d = any_pend ? S_ISSUE : S_IDLE;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d   = (state_d != S_IDLE);
        strobe_d = gnt_eff;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= COIN_Q;
            hold_q   <= '0;
            strobe_q <= 3'b000;
            soda_q   <= 1'b0;
            change_q <= CHG_NONE;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            soda_q   <= soda_d;
            change_q <= change_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign {quarter_o, dime_o, nickle_o} = strobe_q;
    assign soda_o      = soda_q;
    assign change_o    = change_q;
    assign reject_o    = reject_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vend_coin_sched.sv
// Bench for vend_coin_sched: directed scenarios plus randomized traffic against
// a cycle-level model of pending coins, grant order and the post-vend freeze.
module tb_vend_coin_sched;
  import vend_pkg::*;

  localparam int MAX_PEND    = 3;
  localparam int HOLD_CYCLES = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         nickle_i = 1'b0;
  logic         dime_i = 1'b0;
  logic         quarter_i = 1'b0;
  logic         soda_i = 1'b0;
  logic [2:0]   change_i = 3'b000;
  logic         nickle_o, dime_o, quarter_o, soda_o, reject_o, busy_o;
  logic [2:0]   change_o;
  sched_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // expected {strobes[2:0], soda, change[2:0], reject, busy}
  logic [8:0] exp_q[$];

  vend_coin_sched #(
    .MAX_PEND    (MAX_PEND),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .nickle_i    (nickle_i),
    .dime_i      (dime_i),
    .quarter_i   (quarter_i),
    .soda_i      (soda_i),
    .change_i    (change_i),
    .nickle_o    (nickle_o),
    .dime_o      (dime_o),
    .quarter_o   (quarter_o),
    .soda_o      (soda_o),
    .change_o    (change_o),
    .reject_o    (reject_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: pending coin counts, last granted type, hold window
  int         pend[3] = '{0, 0, 0};
  int         last_g = 2;
  int         hold_rem = 0;
  logic [2:0] m_change = 3'b000;

  always @(posedge clk) begin : model
    logic [2:0] p;
    logic [2:0] strobes;
    logic       rej;
    logic       busy;
    int         g;
    p = {quarter_i, dime_i, nickle_i};
    if (!rst_n) begin
      pend     = '{0, 0, 0};
      last_g   = 2;
      hold_rem = 0;
      m_change = 3'b000;
      exp_q.push_back(9'd0);
    end else begin
      g = -1;
      if (!soda_i && hold_rem <= 1) begin
        for (int k = 1; k <= 3; k++) begin
          int t;
          t = (last_g + k) % 3;
          if (g < 0 && pend[t] > 0) g = t;
        end
      end
      rej = 1'b0;
      strobes = 3'b000;
      for (int t = 0; t < 3; t++) begin
        if (p[t] && g != t) begin
          if (pend[t] == MAX_PEND) rej = 1'b1;
          else pend[t] = pend[t] + 1;
        end else if (!p[t] && g == t) begin
          pend[t] = pend[t] - 1;
        end
      end
      if (g >= 0) begin
        last_g = g;
        strobes[g] = 1'b1;
      end
      if (soda_i) begin
        hold_rem = HOLD_CYCLES;
        m_change = change_i;
      end else if (hold_rem > 0) begin
        hold_rem = hold_rem - 1;
      end
      busy = (hold_rem > 0) || (pend[0] + pend[1] + pend[2] > 0);
      exp_q.push_back({strobes, soda_i, m_change, rej, busy});
    end
  end

  // scoreboard compare, every cycle, 1 time unit after the edge
  always @(posedge clk) begin : compare
    logic [8:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL m_queue: got empty expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("m_strobes", 8'({quarter_o, dime_o, nickle_o}), 8'(e[8:6]));
      chk("m_soda",    8'(soda_o),   8'(e[5]));
      chk("m_change",  8'(change_o), 8'(e[4:2]));
      chk("m_reject",  8'(reject_o), 8'(e[1]));
      chk("m_busy",    8'(busy_o),   8'(e[0]));
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_coins(input logic [2:0] c);
    {quarter_i, dime_i, nickle_i} = c;
  endtask

  task automatic chk_str(input string nm, input logic [2:0] exp);
    chk(nm, 8'({quarter_o, dime_o, nickle_o}), 8'(exp));
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin : stim
    int unsigned dens;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk_str("rst_strobes", 3'b000);
    chk("rst_soda",   8'(soda_o),   8'd0);
    chk("rst_change", 8'(change_o), 8'd0);
    chk("rst_reject", 8'(reject_o), 8'd0);
    chk("rst_busy",   8'(busy_o),   8'd0);
    chk("rst_state",  8'(dbg_state), 8'(S_IDLE));
    rst_n = 1'b1;
    cyc();

    // single dime in IDLE
    cyc(); set_coins(3'b010);
    cyc(); set_coins(3'b000);
    chk_str("dime_e0", 3'b000); chk("dime_busy_e0", 8'(busy_o), 8'd1);
    cyc(); chk_str("dime_e1", 3'b010); chk("dime_busy_e1", 8'(busy_o), 8'd0);
    cyc(); chk_str("dime_e2", 3'b000); chk("dime_busy_e2", 8'(busy_o), 8'd0);

    // N, D, Q together after reset
    do_reset();
    set_coins(3'b111);
    cyc(); set_coins(3'b000); chk_str("ndq_e0", 3'b000);
    cyc(); chk_str("ndq_e1", 3'b001);
    cyc(); chk_str("ndq_e2", 3'b010);
    cyc(); chk_str("ndq_e3", 3'b100);
    cyc(); chk_str("ndq_e4", 3'b000); chk("ndq_busy", 8'(busy_o), 8'd0);

    // vend while two nickels are pending
    set_coins(3'b001);
    cyc(); soda_i = 1'b1; change_i = CHG_10; chk_str("vend_e0", 3'b000);
    cyc(); set_coins(3'b000); soda_i = 1'b0; change_i = 3'b000;
    chk("vend_soda_e1", 8'(soda_o), 8'd1); chk("vend_chg_e1", 8'(change_o), 8'h2);
    chk_str("vend_e1", 3'b000); chk("vend_busy_e1", 8'(busy_o), 8'd1);
    cyc(); chk("vend_soda_e2", 8'(soda_o), 8'd0); chk_str("vend_e2", 3'b000);
    cyc(); chk_str("vend_e3", 3'b000);
    cyc(); chk_str("vend_e4", 3'b001);
    cyc(); chk_str("vend_e5", 3'b001);
    cyc(); chk_str("vend_e6", 3'b000); chk("vend_chg_e6", 8'(change_o), 8'h2);
    chk("vend_busy_e6", 8'(busy_o), 8'd0);

    // four quarters during a (restarted) hold window
    soda_i = 1'b1; change_i = CHG_5; set_coins(3'b100);
    cyc(); soda_i = 1'b0;
    chk("q_soda_e0", 8'(soda_o), 8'd1); chk("q_chg_e0", 8'(change_o), 8'h1);
    cyc(); soda_i = 1'b1; change_i = CHG_15;
    chk("q_soda_e1", 8'(soda_o), 8'd0); chk_str("q_e1", 3'b000); chk("q_rej_e1", 8'(reject_o), 8'd0);
    cyc(); soda_i = 1'b0;
    chk("q_chg_e2", 8'(change_o), 8'h3); chk_str("q_e2", 3'b000);
    cyc(); set_coins(3'b000);
    chk("q_rej_e3", 8'(reject_o), 8'd1); chk_str("q_e3", 3'b000);
    cyc(); chk("q_rej_e4", 8'(reject_o), 8'd0); chk_str("q_e4", 3'b000);
    cyc(); chk_str("q_e5", 3'b100);
    cyc(); chk_str("q_e6", 3'b100);
    cyc(); chk_str("q_e7", 3'b100);
    cyc(); chk_str("q_e8", 3'b000); chk("q_busy_e8", 8'(busy_o), 8'd0);

    // nickel pulse in the same cycle as a nickel grant
    set_coins(3'b001);
    cyc(); chk_str("nn_e0", 3'b000);
    cyc(); set_coins(3'b000); chk_str("nn_e1", 3'b001);
    cyc(); chk_str("nn_e2", 3'b001); chk("nn_rej_e2", 8'(reject_o), 8'd0);
    cyc(); chk_str("nn_e3", 3'b000); chk("nn_rej_e3", 8'(reject_o), 8'd0);

    // asynchronous reset in the middle of a hold with coins pending
    soda_i = 1'b1; change_i = 3'b101; set_coins(3'b111);
    cyc(); soda_i = 1'b0; change_i = 3'b000; set_coins(3'b000);
    chk("ar_soda_pre", 8'(soda_o), 8'd1); chk("ar_chg_pre", 8'(change_o), 8'h5);
    #2 rst_n = 1'b0;
    #1;
    chk_str("ar_strobes", 3'b000);
    chk("ar_soda",   8'(soda_o),   8'd0);
    chk("ar_change", 8'(change_o), 8'd0);
    chk("ar_reject", 8'(reject_o), 8'd0);
    chk("ar_busy",   8'(busy_o),   8'd0);
    cyc();
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk_str("ar_quiet", 3'b000); chk("ar_quiet_busy", 8'(busy_o), 8'd0);
    end
    set_coins(3'b011);
    cyc(); set_coins(3'b000); chk_str("ar_nd_e0", 3'b000);
    cyc(); chk_str("ar_nd_e1", 3'b001);
    cyc(); chk_str("ar_nd_e2", 3'b010);
    cyc(); chk_str("ar_nd_e3", 3'b000);

    // randomized traffic with varying coin density, vends and rare resets
    for (int blk = 0; blk < 15; blk++) begin
      dens = $urandom_range(1, 6);
      for (int c = 0; c < 200; c++) begin
        cyc();
        rst_n     = ($urandom_range(0, 599) != 0);
        nickle_i  = ($urandom_range(0, 7) < dens);
        dime_i    = ($urandom_range(0, 7) < dens);
        quarter_i = ($urandom_range(0, 7) < dens);
        soda_i    = ($urandom_range(0, 19) == 0);
        change_i  = 3'($urandom_range(0, 7));
      end
    end
    cyc();
    rst_n = 1'b1;
    set_coins(3'b000);
    soda_i = 1'b0;
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_coin_sched.md
# vend_coin_sched

Coin scheduler between the coin-acceptor sensors and the vending core (`design_1`). It buffers coin pulses that arrive in the same cycle or while the core is dispensing, and forwards them to the core at most one coin per cycle in round-robin order. It also freezes coin delivery for a fixed window after each vend, and registers the core's soda/change result toward the machine outputs.

## Interface
- `MAX_PEND`, default 3: maximum pending coins per coin type; the counter saturates at this value.
- `HOLD_CYCLES`, default 3: number of cycles coin delivery is suppressed after the core signals a vend.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `nickle_i`, `dime_i`, `quarter_i`  in  1 each  sensor pulses, one cycle per coin; any combination may be high in the same cycle.
- `soda_i`  in  1  core vend indication, one-cycle pulse.
- `change_i`  in  3  core change code, valid when `soda_i` is high.
- `nickle_o`, `dime_o`, `quarter_o`  out  1 each  coin strobes to the core; one-hot or all zero.
- `soda_o`  out  1  registered vend pulse.
- `change_o`  out  3  registered change code; held until the next vend.
- `reject_o`  out  1  one-cycle pulse: a coin was dropped because its pending count was already at `MAX_PEND`.
- `busy_o`  out  1  high while in ISSUE or HOLD.

## Operation
- **Pending counters**
  - One counter per coin type, N/D/Q, each `$clog2(MAX_PEND+1)` bits wide.
  - Sensor pulse increments the counter; a grant of that type decrements it.
  - Increment and grant in the same cycle: count unchanged.
  - Increment while at `MAX_PEND` with no grant: count stays, `reject_o` pulses. If several types overflow in one cycle, `reject_o` is a single pulse.
- **Round-robin grant**
  - Order is N → D → Q → N.
  - `last_q` holds the last granted type. The next grant is the first type after `last_q` whose count is nonzero.
  - `last_q` resets to Q, so N has first priority after reset.
- **FSM states:** IDLE, ISSUE, HOLD.
  - IDLE → ISSUE: any count nonzero, or any sensor pulse this cycle.
  - ISSUE: one grant per cycle. → IDLE when all counts reach 0 and no sensor pulse is present.
  - Any state → HOLD on `soda_i`. Load `hold_cnt = HOLD_CYCLES-1`, capture `change_i` into `change_o`, set `soda_o` for one cycle.
  - HOLD: no grants. Counters still accept coins.
  - HOLD exits when `hold_cnt == 0`: → ISSUE if any count is nonzero, else → IDLE.
  - `soda_i` arriving during HOLD restarts the hold window and recaptures `change_o`.
- **Suppression:** a grant decided in the same cycle that `soda_i` is high is suppressed; no strobe is issued and the count is not decremented.
- **Reset** (asynchronous assert, at any point including mid-hold):
  - All counters, `hold_cnt` and strobes go to 0.
  - FSM → IDLE; `last_q` → Q.
  - `soda_o` = 0, `change_o` = 3'b000, `reject_o` = 0, `busy_o` = 0.
  - Pending coins are discarded.

## Timing
- All outputs are registered; none is combinational from inputs.
- Sensor pulse sampled at edge E0 in IDLE with empty counters: the matching strobe is high in the cycle following edge E1 (latency 1 cycle after the sample edge).
- Strobes are single-cycle. Back-to-back strobes occur in consecutive cycles while pending coins remain.
- `soda_i` sampled at edge E: from E onward `soda_o` is high for one cycle, `change_o` is updated, and strobes are 0 for `HOLD_CYCLES` cycles. The first possible strobe is at edge E+`HOLD_CYCLES`.
- `reject_o` is asserted in the cycle after the overflowing pulse is sampled.

## Structure
- Shared package `vend_pkg`, containing:
  - `coin_e` enum {COIN_N, COIN_D, COIN_Q}.
  - `sched_state_e` enum {S_IDLE, S_ISSUE, S_HOLD}.
  - Change-code constants, shared with `design_1`.
- One natural sub-module: `rr_arb3`, a 3-requester combinational round-robin picker. Inputs are `req[2:0]` and `last`; outputs are one-hot `gnt` and its encoded index.
- Counters, FSM and output registers live in the top module.

## Test plan
- Single dime pulse in IDLE: `dime_o` high exactly one cycle, 1 cycle after the sample edge; `busy_o` returns low afterward.
- N, D and Q pulsed in the same cycle after reset: strobes `nickle_o`, `dime_o`, `quarter_o` on three consecutive cycles, in that order.
- Four quarter pulses while in HOLD with `MAX_PEND=3`: one `reject_o` pulse; after HOLD ends, exactly 3 `quarter_o` strobes.
- `soda_i`=1 with `change_i`=3'b010 while 2 nickels are pending: `soda_o` pulses once, `change_o`=3'b010 is held, and no strobe occurs for 3 cycles. Then 2 `nickle_o` strobes follow.
- Nickel pulse in the same cycle as a nickel grant, with count 1: a second `nickle_o` strobe follows on the next cycle; no reject.
- `rst_ni` dropped mid-HOLD with pending coins: all outputs are 0 immediately, asynchronously. After release, no strobes occur without new pulses, and the first new N+D pair grants N first.
